integer_seq_alu: RTL

INTEGER_SEQ_ALU -- requirements
Module: integer_seq_alu

---
 rtl/integer_seq_alu.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/integer_seq_alu.sv
// integer_seq_alu: sequential integer ALU with valid/ready handshake on both sides.
// Single-cycle ops (add/sub, shifts, compares, logic, address adds, branch compares)
// complete with latency 1; results are held in DONE until the consumer takes them.
// Optional feature macro: RISCUINHO_ALU_MDIV_EN adds DIV/DIVU/REM/REMU as an iterative
// restoring divider that spends DATA_WIDTH cycles in EXEC. Without it, EXEC is never
// entered and busy is tied low.
module integer_seq_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           alu_op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  branch,
  output logic                  busy
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [5:0] F7_BASE    = 6'b000000;
  localparam logic [5:0] F7_ALT     = 6'b100000;
`ifdef RISCUINHO_ALU_MDIV_EN
  localparam logic [5:0] F7_MDIV    = 6'b000001;
  localparam int         CNT_W      = $clog2(DATA_WIDTH) + 1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  branch_q, branch_d;

  logic [5:0]            funct7;
  logic [2:0]            funct3;
  logic [6:0]            opcode;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] sum, diff;
  logic                  lt_s, lt_u, eq;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  br_cond, br_taken;
  logic                  accept;

  assign {funct7, funct3, opcode} = alu_op;
  assign shamt = B[SHAMT_W-1:0];
  assign sum   = A + B;
  assign diff  = A - B;
  assign lt_s  = $signed(A) < $signed(B);
  assign lt_u  = A < B;
  assign eq    = (A == B);

`ifdef RISCUINHO_ALU_MDIV_EN
  logic                  div_op;
  logic                  dsigned, a_neg, b_neg;
  logic [DATA_WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sel_rem_q, sel_rem_d;
  logic                  quo_neg_q, quo_neg_d;
  logic                  rem_neg_q, rem_neg_d;
  logic [DATA_WIDTH:0]   trial;
  logic [DATA_WIDTH-1:0] step_sub, step_quo, step_rem, div_res;
  logic                  div_last;
`endif

  // Decode the offered op; produce its single-cycle result and raw branch condition.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    alu_res = '0;
    br_cond = 1'b0;
`ifdef RISCUINHO_ALU_MDIV_EN
    div_op  = 1'b0;
`endif
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  alu_res = sum;
            3'b001:  alu_res = A << shamt;
            3'b010:  alu_res = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            3'b011:  alu_res = {{(DATA_WIDTH-1){1'b0}}, lt_u};
            3'b100:  alu_res = A ^ B;
            3'b101:  alu_res = A >> shamt;
            3'b110:  alu_res = A | B;
            default: alu_res = A & B;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  alu_res = diff;
            3'b101:  alu_res = $unsigned($signed(A) >>> shamt);
            default: ;
          endcase
        end
`ifdef RISCUINHO_ALU_MDIV_EN
        else if (funct7 == F7_MDIV) begin
          div_op = funct3[2];
        end
`endif
      end
      OPC_IMM: begin
        case (funct3)
          3'b000:  alu_res = sum;
          3'b001:  alu_res = A << shamt;
          3'b010:  alu_res = {{(DATA_WIDTH-1){1'b0}}, lt_s};
          3'b011:  alu_res = {{(DATA_WIDTH-1){1'b0}}, lt_u};
          3'b100:  alu_res = A ^ B;
          3'b101:  alu_res = funct7[5] ? $unsigned($signed(A) >>> shamt) : (A >> shamt);
          3'b110:  alu_res = A | B;
          default: alu_res = A & B;
        endcase
      end
      OPC_LOAD, OPC_STORE: alu_res = sum;
      OPC_BRANCH: begin
        case (funct3)
          3'b000:  begin alu_res = sum; br_cond = eq;    end
          3'b001:  begin alu_res = sum; br_cond = !eq;   end
          3'b100:  begin alu_res = sum; br_cond = lt_s;  end
          3'b101:  begin alu_res = sum; br_cond = !lt_s; end
          3'b110:  begin alu_res = sum; br_cond = lt_u;  end
          3'b111:  begin alu_res = sum; br_cond = !lt_u; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Clean the branch flag: an unknown compare falls through to "not taken".
  always_comb begin
    if (br_cond) br_taken = 1'b1;
    else         br_taken = 1'b0;
  end

`ifdef RISCUINHO_ALU_MDIV_EN
  // Operand conditioning at accept and one restoring-division step per EXEC cycle.
  always_comb begin
    dsigned  = !funct3[0];
    a_neg    = dsigned && A[DATA_WIDTH-1];
    b_neg    = dsigned && B[DATA_WIDTH-1];
    trial    = {rem_q, quo_q[DATA_WIDTH-1]};
    step_sub = trial[DATA_WIDTH-1:0] - dvs_q;
    if (trial >= {1'b0, dvs_q}) begin
      step_rem = step_sub;
      step_quo = {quo_q[DATA_WIDTH-2:0], 1'b1};
    end else begin
      step_rem = trial[DATA_WIDTH-1:0];
      step_quo = {quo_q[DATA_WIDTH-2:0], 1'b0};
    end
    if (sel_rem_q) div_res = rem_neg_q ? -step_rem : step_rem;
    else           div_res = quo_neg_q ? -step_quo : step_quo;
    div_last = (cnt_q == CNT_W'(DATA_WIDTH - 1));
  end
`endif

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign branch    = branch_q;
`ifdef RISCUINHO_ALU_MDIV_EN
  assign busy      = (state_q == EXEC);
`else
  assign busy      = 1'b0;
`endif

  // Next-state and next-result logic for the IDLE/EXEC/DONE handshake FSM.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    branch_d = branch_q;
`ifdef RISCUINHO_ALU_MDIV_EN
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    sel_rem_d = sel_rem_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
`ifdef RISCUINHO_ALU_MDIV_EN
          if (div_op) begin
            state_d   = EXEC;
            out_d     = '0;
            branch_d  = 1'b0;
            quo_d     = a_neg ? -A : A;
            dvs_d     = b_neg ? -B : B;
            rem_d     = '0;
            cnt_d     = '0;
            sel_rem_d = funct3[1];
            // Divide by zero keeps the raw all-ones quotient; only a real divisor flips sign.
            quo_neg_d = dsigned && (A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1]) && (|B);
            rem_neg_d = a_neg;
          end else
`endif
          begin
            state_d  = DONE;
            out_d    = alu_res;
            branch_d = br_taken;
          end
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
`ifdef RISCUINHO_ALU_MDIV_EN
      EXEC: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + CNT_W'(1);
        if (div_last) begin
          state_d  = DONE;
          out_d    = div_res;
          branch_d = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and held-result registers; reset overrides any accept or completion.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q  <= IDLE;
      out_q    <= '0;
      branch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      branch_q <= branch_d;
    end
  end

`ifdef RISCUINHO_ALU_MDIV_EN
  // Divider working registers; reset clears them so an abandoned divide leaves nothing behind.
  always_ff @(posedge clk) begin
    // NOTE: the divider datapath is reset too; it is a handful of flops, not a memory, and a clean restart is simpler to reason about.
    if (reset) begin
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      sel_rem_q <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      sel_rem_q <= sel_rem_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end
`endif

endmodule
